// File: rtl/cdc_pkg.sv
// Shared constants and types for the I2S-to-DSP packet receiver.
// pkt_t and frame_t describe the default configuration.
package cdc_pkg;

  localparam int PKT_WIDTH_DEF   = 16;
  localparam int NUM_CH_DEF      = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FIFO_DEPTH_DEF  = 4;

  typedef logic [PKT_WIDTH_DEF-1:0]            pkt_t;
  typedef logic [NUM_CH_DEF*PKT_WIDTH_DEF-1:0] frame_t;

  // Index width that stays legal when only one entry exists.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_frame_fifo.sv
// Synchronous first-word-fall-through frame FIFO with occupancy output.
// A push is accepted when not full, or when a pop happens in the same cycle.
module cdc_frame_fifo
  import cdc_pkg::*;
#(
  parameter int WIDTH = NUM_CH_DEF * PKT_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clkDSP_i,
  input  logic                     rstDSP_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     popReady_i,
  output logic [WIDTH-1:0]         headData_o,
  output logic                     headValid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wrEn;

  // The extra pointer MSB separates the full and empty cases.
  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop     = !empty && popReady_i;
  assign wrEn    = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;
  assign level_o = wrPtr - rdPtr;

  assign headValid_o = !empty;
  assign headData_o  = empty ? '0 : mem[rdPtr[AW-1:0]];

  always_ff @(posedge clkDSP_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rstDSP_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale entries on the output.
  always_ff @(posedge clkDSP_i) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/cdc_pkt_rx.sv
// Receives toggle-qualified audio packets from the I2S domain, assembles
// frames and queues them for the DSP. Optional macro: CDC_OVF_CNT_EN.
module cdc_pkt_rx
  import cdc_pkg::*;
#(
  parameter int PKT_WIDTH   = PKT_WIDTH_DEF,
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                          clkDSP_i,
  input  logic                          rstDSP_i,
  input  logic                          pktToggleI2S_i,
  input  logic [PKT_WIDTH-1:0]          pktI2S_i,
  input  logic                          pktFirstI2S_i,
  output logic [NUM_CH*PKT_WIDTH-1:0]   frameDSP_o,
  output logic                          frameValidDSP_o,
  input  logic                          frameReadyDSP_i,
  output logic                          frameChangedDSP_comb_o,
  output logic [$clog2(FIFO_DEPTH):0]   levelDSP_o,
`ifdef CDC_OVF_CNT_EN
  output logic [7:0]                    ovfCntDSP_o,
`endif
  output logic                          ovfDSP_o
);

  localparam int FW   = NUM_CH * PKT_WIDTH;
  localparam int CH_W = idxWidth(NUM_CH);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   syncLast;
  logic                   prevQ;
  logic                   pktEdge;

  logic [CH_W-1:0] chIdx;
  logic [CH_W-1:0] chNext;
  logic [CH_W-1:0] slot;
  logic [FW-1:0]   asmQ;
  logic [FW-1:0]   asmNext;
  logic            pushNext;
  logic            pushQ;
  logic [FW-1:0]   pushFrameQ;
  logic [FW-1:0]   lastPopped;
  logic            pop;
  logic            drop;

  // Synchroniser is left unreset so a held toggle settles during reset.
  always_ff @(posedge clkDSP_i) begin
    syncQ <= {syncQ[SYNC_STAGES-2:0], pktToggleI2S_i};
    prevQ <= syncLast;
  end

  assign syncLast = syncQ[SYNC_STAGES-1];
  assign pktEdge  = syncLast ^ prevQ;

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    asmNext  = asmQ;
    chNext   = chIdx;
    pushNext = 1'b0;
    slot     = chIdx;
    if (pktEdge) begin
      if (pktFirstI2S_i) begin
        slot    = '0;
        asmNext = '0;
      end
      asmNext[int'(slot)*PKT_WIDTH +: PKT_WIDTH] = pktI2S_i;
      if (slot == CH_W'(NUM_CH - 1)) begin
        pushNext = 1'b1;
        chNext   = '0;
      end else begin
        chNext = slot + 1'b1;
      end
    end
  end

  // The completed frame is registered once more before entering the FIFO.
  always_ff @(posedge clkDSP_i) begin
    if (rstDSP_i) begin
      chIdx      <= '0;
      asmQ       <= '0;
      pushQ      <= 1'b0;
      pushFrameQ <= '0;
    end else begin
      chIdx      <= chNext;
      asmQ       <= asmNext;
      pushQ      <= pushNext;
      pushFrameQ <= asmNext;
    end
  end

  cdc_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clkDSP_i    (clkDSP_i),
    .rstDSP_i    (rstDSP_i),
    .push_i      (pushQ),
    .pushData_i  (pushFrameQ),
    .popReady_i  (frameReadyDSP_i),
    .headData_o  (frameDSP_o),
    .headValid_o (frameValidDSP_o),
    .level_o     (levelDSP_o),
    .drop_o      (drop)
  );

  assign pop                    = frameValidDSP_o && frameReadyDSP_i;
  assign frameChangedDSP_comb_o = pop && (frameDSP_o != lastPopped);

  always_ff @(posedge clkDSP_i) begin
    if (rstDSP_i) begin
      lastPopped <= '0;
      ovfDSP_o   <= 1'b0;
    end else begin
      if (pop)  lastPopped <= frameDSP_o;
      if (drop) ovfDSP_o   <= 1'b1;
    end
  end

`ifdef CDC_OVF_CNT_EN
  always_ff @(posedge clkDSP_i) begin
    if (rstDSP_i)                        ovfCntDSP_o <= '0;
    else if (drop && ovfCntDSP_o != 8'hFF) ovfCntDSP_o <= ovfCntDSP_o + 8'd1;
  end
`else
  // Without the counter, dropped frames are reported only by the sticky flag.
`endif

endmodule

// File: tb/tb_cdc_pkt_rx.sv
// Self-checking bench for cdc_pkt_rx: table vectors, directed corner cases
// and randomized packets against a frame-level reference model.
module tb_cdc_pkt_rx;
  import cdc_pkg::*;

  localparam int PW = PKT_WIDTH_DEF;
  localparam int NC = NUM_CH_DEF;
  localparam int SS = SYNC_STAGES_DEF;
  localparam int FD = FIFO_DEPTH_DEF;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          toggle = 1'b0;
  pkt_t          pkt = '0;
  logic          first = 1'b0;
  frame_t        frame;
  logic          valid;
  logic          ready = 1'b0;
  logic          changed;
  logic [LW-1:0] level;
  logic          ovf;
`ifdef CDC_OVF_CNT_EN
  logic [7:0]    ovfCnt;
`endif

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  cdc_pkt_rx #(
    .PKT_WIDTH   (PW),
    .NUM_CH      (NC),
    .SYNC_STAGES (SS),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clkDSP_i               (clk),
    .rstDSP_i               (rst),
    .pktToggleI2S_i         (toggle),
    .pktI2S_i               (pkt),
    .pktFirstI2S_i          (first),
    .frameDSP_o             (frame),
    .frameValidDSP_o        (valid),
    .frameReadyDSP_i        (ready),
    .frameChangedDSP_comb_o (changed),
    .levelDSP_o             (level),
`ifdef CDC_OVF_CNT_EN
    .ovfCntDSP_o            (ovfCnt),
`endif
    .ovfDSP_o               (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendPkt(input pkt_t d, input bit f);
    pkt    = d;
    first  = f;
    toggle = ~toggle;
    cycles(6);
  endtask

  task automatic sendFrame(input pkt_t lo, input pkt_t hi);
    sendPkt(lo, 1'b1);
    sendPkt(hi, 1'b0);
  endtask

  task automatic applyReset();
    rst   = 1'b1;
    ready = 1'b0;
    cycles(4);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic popCheck(input string name, input frame_t exp, input bit expChg);
    ready = 1'b1;
    @(negedge clk);
    check({name, " valid"}, 64'(valid), 64'd1);
    check({name, " frame"}, 64'(frame), 64'(exp));
    check({name, " changed"}, 64'(changed), 64'(expChg));
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  // Frame-level reference model: packets accumulate until a frame is complete.
  pkt_t   mParts[$];
  frame_t mQueue[$];
  bit     mOvf;
  int     mCnt;
  frame_t mLast;

  function automatic void modelPkt(input pkt_t d, input bit f);
    frame_t fr;
    if (f) mParts.delete();
    mParts.push_back(d);
    if (mParts.size() == NC) begin
      fr = '0;
      for (int i = 0; i < NC; i++) fr[i*PW +: PW] = mParts[i];
      mParts.delete();
      if (mQueue.size() < FD) mQueue.push_back(fr);
      else begin
        mOvf = 1'b1;
        if (mCnt < 255) mCnt++;
      end
    end
  endfunction

  typedef struct {
    pkt_t lo;
    pkt_t hi;
    bit   expChg;
  } chg_vec_t;

  chg_vec_t chgTab[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    chgTab[0] = '{16'h0001, 16'h0001, 1'b1};
    chgTab[1] = '{16'h0001, 16'h0001, 1'b0};
    chgTab[2] = '{16'h0001, 16'h0002, 1'b1};
    chgTab[3] = '{16'h0001, 16'h0002, 1'b0};
    chgTab[4] = '{16'h0000, 16'hFFFF, 1'b1};
    chgTab[5] = '{16'h0000, 16'h0000, 1'b1};

    @(posedge clk);
    #1;
    applyReset();

    // Reset state
    @(negedge clk);
    check("reset valid", 64'(valid), 64'd0);
    check("reset frame", 64'(frame), 64'd0);
    check("reset level", 64'(level), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
`ifdef CDC_OVF_CNT_EN
    check("reset ovfCnt", 64'(ovfCnt), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Latency from the second flip to valid
    sendPkt(16'h0001, 1'b1);
    pkt    = 16'h0002;
    first  = 1'b0;
    toggle = ~toggle;
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    check("latency early valid", 64'(valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency valid", 64'(valid), 64'd1);
    check("latency frame", 64'(frame), 64'h0002_0001);
    check("latency level", 64'(level), 64'd1);
    cycles(2);
    popCheck("latency pop", 32'h0002_0001, 1'b1);

    // Changed flag vectors
    applyReset();
    for (int i = 0; i < 6; i++) begin
      sendFrame(chgTab[i].lo, chgTab[i].hi);
      popCheck($sformatf("chgTab[%0d]", i), {chgTab[i].hi, chgTab[i].lo}, chgTab[i].expChg);
    end

    // Overflow: five frames into a four-entry FIFO
    applyReset();
    for (int i = 0; i < 5; i++) sendFrame(pkt_t'(16'h0010 + i), pkt_t'(16'hA000 + i));
    @(negedge clk);
    check("ovf level", 64'(level), 64'(FD));
    check("ovf flag", 64'(ovf), 64'd1);
`ifdef CDC_OVF_CNT_EN
    check("ovf count", 64'(ovfCnt), 64'd1);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      popCheck($sformatf("ovf pop%0d", i), {pkt_t'(16'hA000 + i), pkt_t'(16'h0010 + i)}, 1'b1);
    @(negedge clk);
    check("ovf drained", 64'(valid), 64'd0);
    check("ovf sticky", 64'(ovf), 64'd1);
    @(posedge clk);
    #1;

    // Resync: A(first), B(first), C gives {C,B}
    applyReset();
    sendPkt(16'hAAAA, 1'b1);
    sendPkt(16'hBBBB, 1'b1);
    sendPkt(16'hCCCC, 1'b0);
    @(negedge clk);
    check("resync level", 64'(level), 64'd1);
    @(posedge clk);
    #1;
    popCheck("resync pop", 32'hCCCC_BBBB, 1'b1);
    cycles(4);
    @(negedge clk);
    check("resync no A", 64'(valid), 64'd0);
    @(posedge clk);
    #1;

    // Push coinciding with pop while full
    applyReset();
    for (int i = 0; i < 4; i++) sendFrame(pkt_t'(16'h0100 + i), pkt_t'(16'hB000 + i));
    sendPkt(16'h0104, 1'b1);
    pkt    = 16'hB004;
    first  = 1'b0;
    toggle = ~toggle;
    cycles(SS + 1);
    ready = 1'b1;
    @(negedge clk);
    check("full pre level", 64'(level), 64'(FD));
    check("full pre head", 64'(frame), 64'hB000_0100);
    cycles(1);
    ready = 1'b0;
    @(negedge clk);
    check("full level kept", 64'(level), 64'(FD));
    check("full no ovf", 64'(ovf), 64'd0);
    cycles(2);
    for (int i = 1; i < 5; i++)
      popCheck($sformatf("full pop%0d", i), {pkt_t'(16'hB000 + i), pkt_t'(16'h0100 + i)}, 1'b1);

    // Toggle flipped and held through reset release
    rst    = 1'b1;
    toggle = ~toggle;
    cycles(5);
    rst = 1'b0;
    cycles(10);
    @(negedge clk);
    check("held toggle level", 64'(level), 64'd0);
    check("held toggle valid", 64'(valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset after one channel captured
    sendPkt(16'h1111, 1'b1);
    applyReset();
    sendPkt(16'h2222, 1'b0);
    sendPkt(16'h3333, 1'b0);
    @(negedge clk);
    check("midreset level", 64'(level), 64'd1);
    @(posedge clk);
    #1;
    popCheck("midreset pop", 32'h3333_2222, 1'b1);

    // Randomized packets against the reference model
    applyReset();
    mParts.delete();
    mQueue.delete();
    mOvf  = 1'b0;
    mCnt  = 0;
    mLast = '0;
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        pkt_t d;
        bit   f;
        d = pkt_t'($urandom);
        f = ($urandom_range(0, 3) == 0);
        modelPkt(d, f);
        sendPkt(d, f);
      end
      @(negedge clk);
      check($sformatf("rnd%0d level", r), 64'(level), 64'(mQueue.size()));
      check($sformatf("rnd%0d ovf", r), 64'(ovf), 64'(mOvf));
`ifdef CDC_OVF_CNT_EN
      check($sformatf("rnd%0d ovfCnt", r), 64'(ovfCnt), 64'(mCnt));
`endif
      @(posedge clk);
      #1;
      while (mQueue.size() > 0) begin
        frame_t e;
        e = mQueue.pop_front();
        popCheck($sformatf("rnd%0d pop", r), e, e != mLast);
        mLast = e;
      end
      @(negedge clk);
      check($sformatf("rnd%0d empty", r), 64'(valid), 64'd0);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/cdc_pkt_rx.md
CDC_PKT_RX -- requirements
Module: cdc_pkt_rx

Interface
REQ-001 SHALL have parameter PKT_WIDTH, default 16: bits per audio packet.
REQ-002 SHALL have parameter NUM_CH, default 2: packets (channels) per frame, >=1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops on the toggle input, >=2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: frame FIFO entries, power of two, >=2.
REQ-005 SHALL have one clock and a synchronous active-high reset; all logic is in the clkDSP_i domain.
REQ-006 SHALL have port clkDSP_i, input, 1: DSP clock.
REQ-007 SHALL have port rstDSP_i, input, 1: synchronous active-high reset.
REQ-008 SHALL have port pktToggleI2S_i, input, 1: asynchronous toggle that flips once per new packet.
REQ-009 SHALL have port pktI2S_i, input, PKT_WIDTH: packet data, stable >= SYNC_STAGES+2 clkDSP_i cycles after each toggle flip.
REQ-010 SHALL have port pktFirstI2S_i, input, 1: marks a channel-0 packet, qualified with pktI2S_i.
REQ-011 SHALL have port frameDSP_o, output, NUM_CH*PKT_WIDTH: FIFO head frame, channel 0 in the LSBs.
REQ-012 SHALL have port frameValidDSP_o, output, 1: FIFO not empty.
REQ-013 SHALL have port frameReadyDSP_i, input, 1: consumer accepts the head frame.
REQ-014 SHALL have port frameChangedDSP_comb_o, output, 1: combinational; popped frame differs from the previously popped frame.
REQ-015 SHALL have port levelDSP_o, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-016 SHALL have port ovfDSP_o, output, 1: sticky overflow flag.

Function
REQ-017 SHALL pass pktToggleI2S_i through a SYNC_STAGES flop chain and detect an edge as sync_last XOR prev.
REQ-018 SHALL capture pktI2S_i and pktFirstI2S_i on the edge-detect cycle; toggle flip to capture latency is SYNC_STAGES+1 cycles.
REQ-019 SHALL hold a channel index chIdx in 0..NUM_CH-1; a capture writes slot chIdx of the assembly register and then increments chIdx.
REQ-020 SHALL write slot 0 and set chIdx=1 when a capture has pktFirstI2S_i=1, discarding any partial frame (resync).
REQ-021 SHALL push the assembled frame on the capture of slot NUM_CH-1 and wrap chIdx to 0; with NUM_CH=1, every capture pushes.
REQ-022 SHALL assert frameValidDSP_o on the cycle after a push into an empty FIFO (first-word fall-through).
REQ-023 SHALL pop when frameValidDSP_o && frameReadyDSP_i; frameReadyDSP_i while empty has no effect.
REQ-024 SHALL accept a push that coincides with a pop, including when full; levelDSP_o is then unchanged.
REQ-025 SHALL drop a push that arrives while full with no pop, and set ovfDSP_o, which holds until reset.
REQ-026 SHALL compute frameChangedDSP_comb_o = pop && (frameDSP_o != lastPopped); lastPopped updates on every pop.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH using an extra MSB to tell full from empty.

Reset
REQ-028 SHALL, in reset, clear the FIFO, levelDSP_o, ovfDSP_o, chIdx, the assembly register and lastPopped, and drive frameValidDSP_o=0 and frameDSP_o=0.
REQ-029 SHALL load prev from sync_last during reset, so reset release causes no spurious edge.
REQ-030 SHALL abort an in-progress frame and discard FIFO contents on reset mid-operation.

Configuration
REQ-031 SHALL, when CDC_OVF_CNT_EN is defined, add output ovfCntDSP_o [7:0], a count of dropped frames that saturates at 255 and clears on reset.
REQ-032 SHALL, when CDC_OVF_CNT_EN is undefined, omit ovfCntDSP_o; only the sticky ovfDSP_o reports overflow.

Structure
REQ-033 SHALL take typedefs pkt_t and frame_t, plus the default parameter constants, from shared package cdc_pkg.
REQ-034 SHALL implement the FIFO as sub-module cdc_frame_fifo (synchronous, FWFT, level output); synchroniser and assembly logic stay in cdc_pkt_rx.

Verification
REQ-035 SHALL check latency: defaults; toggle 0->1 with pkt 0x0001 (first=1), then 0x0002 -> frameValidDSP_o rises with frameDSP_o=0x00020001 exactly SYNC_STAGES+2 cycles after the second flip.
REQ-036 SHALL check overflow: ready=0; 5 complete frames -> levelDSP_o=4, ovfDSP_o=1, ovfCntDSP_o=1 (with CDC_OVF_CNT_EN), and the first 4 frames pop in order.
REQ-037 SHALL check resync: packets A(first), B(first), C -> single frame {C,B}; A is never output.
REQ-038 SHALL check push and pop while full: full FIFO with ready=1 on the push cycle -> levelDSP_o stays 4 and ovfDSP_o stays 0.
REQ-039 SHALL check the changed flag: pop 0x00010001 twice, then 0x00020001 -> frameChangedDSP_comb_o is 1, 0, 1.
REQ-040 SHALL check reset: pktToggleI2S_i=1 held through reset release -> no push; reset after one channel captured -> next frame assembles cleanly from slot 0.
